// File: rtl/pipe_share_pkg.sv
// Shared constants and width helpers for the shared-pipeline scheduler.
package pipe_share_pkg;

    localparam int unsigned DEF_PORTS      = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_LAT        = 3;
    localparam int unsigned DEF_OUT_DEPTH  = 8;

    // Index width, never below one bit so single-entry structures still get a pointer.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Stage record is {valid, id, data}; valid is kept in its own vector,
    // so the stored payload is {id, data}.
    localparam int unsigned STG_VALID_W = 1;

    function automatic int unsigned payload_width(input int unsigned id_w,
                                                  input int unsigned data_w);
        return id_w + data_w;
    endfunction

    function automatic int unsigned stage_width(input int unsigned id_w,
                                                input int unsigned data_w);
        return STG_VALID_W + payload_width(id_w, data_w);
    endfunction

    localparam int unsigned DEF_ID_WIDTH   = idx_width(DEF_PORTS);
    localparam int unsigned DEF_USED_WIDTH = cnt_width(DEF_OUT_DEPTH);
    localparam int unsigned DEF_STAGE_W    = stage_width(DEF_ID_WIDTH, DEF_DATA_WIDTH);

endpackage

// File: rtl/pipe_share_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr wins, wrapping to the lowest index.
module rr_arbiter
    import pipe_share_pkg::*;
#(
    parameter int unsigned PORTS = DEF_PORTS,
    parameter int unsigned IDX_W = DEF_ID_WIDTH
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [PORTS-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic found;

    // Two passes over constant indices: upper segment [ptr..PORTS-1], then the wrap.
    always_comb begin
        found     = 1'b0;
        grant_idx = ptr;
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (!found && req[p] && (IDX_W'(p) >= ptr)) begin
                found     = 1'b1;
                grant_idx = IDX_W'(p);
            end
        end
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (!found && req[p]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(p);
            end
        end
        grant = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            grant[p] = enable && found && (grant_idx == IDX_W'(p));
        end
    end

endmodule

// File: rtl/pipe_share_sched.sv
// Shares one fixed-latency pipeline among PORTS requesters; credit-limited so the
// output FIFO can always absorb everything in flight.
module pipe_share_sched
    import pipe_share_pkg::*;
#(
    parameter int unsigned PORTS      = DEF_PORTS,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LAT        = DEF_LAT,
    parameter int unsigned OUT_DEPTH  = DEF_OUT_DEPTH,
    parameter int unsigned ID_WIDTH   = idx_width(PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS-1:0]              s_valid,
    output logic [PORTS-1:0]              s_ready,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [ID_WIDTH-1:0]           m_id,
    output logic [cnt_width(OUT_DEPTH)-1:0] used,
    output logic                          busy
);

    localparam int unsigned UW = cnt_width(OUT_DEPTH);
    localparam int unsigned PW = payload_width(ID_WIDTH, DATA_WIDTH);
    localparam int unsigned AW = idx_width(OUT_DEPTH);
    localparam logic [UW-1:0] CREDITS = UW'(OUT_DEPTH);

    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [PORTS-1:0]      grant;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  can_issue, issue, pop, fifo_wr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic [LAT-1:0]        stg_vld_q, stg_vld_d;
    logic [PW-1:0]         stg_pay_q [LAT];
    logic [PW-1:0]         stg_pay_d [LAT];

    logic [PW-1:0]         mem_q [OUT_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic [UW-1:0]         used_q, used_d;

    assign can_issue = (used_q < CREDITS);

    rr_arbiter #(
        .PORTS (PORTS),
        .IDX_W (ID_WIDTH)
    ) u_arb (
        .req       (s_valid),
        .ptr       (ptr_q),
        .enable    (can_issue && !rst),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign s_ready = grant;
    assign issue   = |grant;
    assign fifo_wr = stg_vld_q[LAT-1];
    assign pop     = m_valid && m_ready;

    always_comb begin
        sel_data = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (grant_idx == ID_WIDTH'(p)) begin
                sel_data = s_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (grant_idx == ID_WIDTH'(PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end

        stg_vld_d[0] = issue;
        stg_pay_d[0] = {grant_idx, sel_data};
        for (int unsigned k = 1; k < LAT; k++) begin
            stg_vld_d[k] = stg_vld_q[k-1];
            stg_pay_d[k] = stg_pay_q[k-1];
        end

        wr_ptr_d = wr_ptr_q;
        if (fifo_wr) begin
            wr_ptr_d = (wr_ptr_q == AW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        fifo_cnt_d = fifo_cnt_q + UW'(fifo_wr) - UW'(pop);
        used_d     = used_q + UW'(issue) - UW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            stg_vld_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            used_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            stg_vld_q  <= stg_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            used_q     <= used_d;
        end
    end

    // Payload storage carries no reset; only the valid bits and counters qualify it.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < LAT; k++) begin
            stg_pay_q[k] <= stg_pay_d[k];
        end
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= stg_pay_q[LAT-1];
        end
    end

    assign m_valid = (fifo_cnt_q != '0);
    assign m_data  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign m_id    = mem_q[rd_ptr_q][PW-1 -: ID_WIDTH];
    assign used    = used_q;
    assign busy    = (used_q != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fifo_wr && fifo_cnt_q == CREDITS));
            assert (!(issue && !pop && used_q == CREDITS));
            assert (!(pop && !issue && used_q == '0));
        end
    end

endmodule

// File: tb/tb_pipe_share_sched.sv
// Randomised and directed checks of pipe_share_sched against a queue-based reference model.
module tb_pipe_share_sched;

    localparam int P  = 4;
    localparam int DW = 32;
    localparam int L  = 3;
    localparam int D  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [P-1:0]    s_valid;
    logic [P-1:0]    s_ready;
    logic [P*DW-1:0] s_data;
    logic            m_valid;
    logic            m_ready;
    logic [DW-1:0]   m_data;
    logic [1:0]      m_id;
    logic [2:0]      used;
    logic            busy;

    always #5 clk = ~clk;

    pipe_share_sched #(
        .PORTS      (P),
        .DATA_WIDTH (DW),
        .LAT        (L),
        .OUT_DEPTH  (D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_id    (m_id),
        .used    (used),
        .busy    (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    endtask

    // Reference model: every accepted request sits in one ordered queue (in flight or
    // buffered) and becomes visible LAT+1 cycles after the cycle it was accepted.
    typedef struct {
        logic [DW-1:0] d;
        int            id;
        int            rc;
    } ent_t;

    ent_t q[$];
    int   mptr     = 0;
    int   cyc      = 0;
    bit   model_on = 1'b0;

    function automatic logic [P-1:0] exp_ready();
        if (rst || q.size() >= D) return '0;
        for (int i = 0; i < P; i++) begin
            int p = (mptr + i) % P;
            if (s_valid[p]) return P'(1 << p);
        end
        return '0;
    endfunction

    function automatic bit exp_mvalid();
        return q.size() > 0 && q[0].rc <= cyc;
    endfunction

    always @(posedge clk) begin
        logic [P-1:0] g;
        bit           pv;
        if (rst) begin
            q.delete();
            mptr     = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            g  = exp_ready();
            pv = exp_mvalid() && m_ready;
            if (pv) void'(q.pop_front());
            for (int p = 0; p < P; p++) begin
                if (g[p]) begin
                    q.push_back('{d: s_data[p*DW +: DW], id: p, rc: cyc + L + 1});
                    mptr = (p + 1) % P;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (model_on) begin
            if (rst) begin
                check("s_ready_in_reset", 64'(s_ready), 64'd0);
            end else begin
                check("s_ready", 64'(s_ready), 64'(exp_ready()));
                check("used", 64'(used), 64'(q.size()));
                check("busy", 64'(busy), 64'(q.size() != 0));
                check("m_valid", 64'(m_valid), 64'(exp_mvalid()));
                if (exp_mvalid()) begin
                    check("m_data", 64'(m_data), 64'(q[0].d));
                    check("m_id", 64'(m_id), 64'(q[0].id));
                end
            end
        end
    end

    task automatic cyc_adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = '0;
        m_ready = 1'b0;
        cyc_adv();
        rst = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [P-1:0] v);
        for (int i = 0; i < P; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        int n_iss;
        int n_pop;
        int prob;

        rst     = 1'b1;
        s_valid = '0;
        m_ready = 1'b0;
        s_data  = '0;
        cyc_adv();
        s_valid = '1;
        cyc_adv();
        @(negedge clk);
        check("rst_forces_s_ready_low", 64'(s_ready), 64'd0);
        cyc_adv();
        rst     = 1'b0;
        s_valid = '0;
        @(negedge clk);
        check("reset_used", 64'(used), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_m_valid", 64'(m_valid), 64'd0);

        // Single request from port 2; result four cycles after the accepting cycle.
        cyc_adv();
        s_valid = 4'b0100;
        s_data[2*DW +: DW] = 32'hA5A5_0002;
        @(negedge clk);
        check("t1_s_ready", 64'(s_ready), 64'h4);
        cyc_adv();
        s_valid = '0;
        @(negedge clk);
        check("t1_m_valid_early1", 64'(m_valid), 64'd0);
        cyc_adv();
        cyc_adv();
        @(negedge clk);
        check("t1_m_valid_early3", 64'(m_valid), 64'd0);
        cyc_adv();
        m_ready = 1'b1;
        @(negedge clk);
        check("t1_m_valid", 64'(m_valid), 64'd1);
        check("t1_m_data", 64'(m_data), 64'hA5A5_0002);
        check("t1_m_id", 64'(m_id), 64'd2);
        check("t1_used", 64'(used), 64'd1);
        cyc_adv();
        m_ready = 1'b0;
        @(negedge clk);
        check("t1_used_drained", 64'(used), 64'd0);
        check("t1_busy_drained", 64'(busy), 64'd0);

        // All ports streaming with a ready consumer: round-robin order end to end.
        do_reset();
        s_valid = '1;
        m_ready = 1'b1;
        n_iss   = 0;
        n_pop   = 0;
        for (int c = 0; c < 30; c++) begin
            s_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (s_ready != '0) begin
                check("t2_grant_order", 64'(onehot_idx(s_ready)), 64'(n_iss % P));
                n_iss++;
            end
            if (m_valid && m_ready) begin
                check("t2_mid_order", 64'(m_id), 64'(n_pop % P));
                n_pop++;
            end
            check("t2_used_bound", 64'(used <= 3'd4), 64'd1);
            cyc_adv();
        end
        check("t2_enough_pops", 64'(n_pop >= 8), 64'd1);

        // Stalled consumer: credits stop issue at four; one pop admits exactly one.
        do_reset();
        s_valid = '1;
        n_iss   = 0;
        for (int c = 0; c < 8; c++) begin
            s_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (s_ready != '0) n_iss++;
            cyc_adv();
        end
        check("t3_issue_count", 64'(n_iss), 64'd4);
        @(negedge clk);
        check("t3_used_full", 64'(used), 64'd4);
        check("t3_s_ready_full", 64'(s_ready), 64'd0);
        check("t3_m_valid", 64'(m_valid), 64'd1);
        m_ready = 1'b1;
        cyc_adv();
        m_ready = 1'b0;
        @(negedge clk);
        check("t3_one_grant", 64'(s_ready), 64'h1);
        check("t3_used_after_pop", 64'(used), 64'd3);
        cyc_adv();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t3_no_extra_grant", 64'(s_ready), 64'd0);
            check("t3_used_refull", 64'(used), 64'd4);
            cyc_adv();
        end

        // Port 1 holds the grant at full credit, then withdraws; port 3 takes it.
        s_valid = 4'b1001;
        @(negedge clk);
        check("t6_s_ready_full", 64'(s_ready), 64'd0);
        m_ready = 1'b1;
        cyc_adv();
        m_ready = 1'b0;
        @(negedge clk);
        check("t6_grant_moves_to_3", 64'(s_ready), 64'h8);
        cyc_adv();

        // Simultaneous issue and pop at used=3 leaves used unchanged.
        s_valid = '0;
        m_ready = 1'b1;
        cyc_adv();
        s_valid = '1;
        @(negedge clk);
        check("t4_used_before", 64'(used), 64'd3);
        check("t4_m_valid", 64'(m_valid), 64'd1);
        check("t4_s_ready", 64'(s_ready), 64'h1);
        cyc_adv();
        s_valid = '0;
        m_ready = 1'b0;
        @(negedge clk);
        check("t4_used_after", 64'(used), 64'd3);

        // Reset with one buffered result and two in the pipe.
        do_reset();
        s_valid = 4'b0001;
        s_data  = {$urandom, $urandom, $urandom, $urandom};
        cyc_adv();
        s_valid = '0;
        cyc_adv();
        s_valid = 4'b0010;
        cyc_adv();
        cyc_adv();
        s_valid = '0;
        rst     = 1'b1;
        @(negedge clk);
        check("t5_m_valid_pre", 64'(m_valid), 64'd1);
        check("t5_used_pre", 64'(used), 64'd3);
        cyc_adv();
        rst     = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("t5_m_valid_post", 64'(m_valid), 64'd0);
        check("t5_used_post", 64'(used), 64'd0);
        for (int c = 0; c < L + 2; c++) begin
            cyc_adv();
            @(negedge clk);
            check("t5_no_stale", 64'(m_valid), 64'd0);
        end
        cyc_adv();
        s_valid = '1;
        @(negedge clk);
        check("t5_grant_port0", 64'(s_ready), 64'h1);
        cyc_adv();

        // Single requester streaming.
        do_reset();
        s_valid = 4'b0100;
        m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            s_data = {$urandom, $urandom, $urandom, $urandom};
            cyc_adv();
        end

        // Randomised traffic with varying consumer pressure and occasional resets.
        do_reset();
        prob = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) prob = $urandom_range(5, 100);
            s_valid = P'($urandom) & P'($urandom | $urandom);
            s_data  = {$urandom, $urandom, $urandom, $urandom};
            m_ready = ($urandom_range(1, 100) <= prob);
            rst     = ($urandom_range(0, 299) == 0);
            cyc_adv();
        end
        rst     = 1'b0;
        s_valid = '0;
        m_ready = 1'b1;
        repeat (12) cyc_adv();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
